simplez_ctrl: RTL and testbench

SIMPLEZ_CTRL -- requirements
Module: simplez_ctrl

---
 rtl/simplez_pkg.sv | 50 +++++
 rtl/simplez_ctrl_if.sv | 31 +++
 rtl/simplez_ctrl_dec.sv | 92 +++++++++
 rtl/simplez_ctrl.sv | 77 +++++++
 tb/tb_simplez_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/simplez_pkg.sv
// Shared constants for the Simplez control unit: opcodes, state codes, ALU ops.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simplez_pkg;

    typedef enum logic [2:0] {
        OP_ST   = 3'd0,
        OP_LD   = 3'd1,
        OP_ADD  = 3'd2,
        OP_BR   = 3'd3,
        OP_BZ   = 3'd4,
        OP_CLR  = 3'd5,
        OP_DEC  = 3'd6,
        OP_HALT = 3'd7
    } opcode_e;

    // Codes 6 and 7 are unused and recover to S_I0.
    typedef enum logic [2:0] {
        S_I0 = 3'd0,
        S_I1 = 3'd1,
        S_D  = 3'd2,
        S_O0 = 3'd3,
        S_O1 = 3'd4,
        S_H  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_DEC  = 2'd2,
        ALU_CLR  = 2'd3
    } alu_op_e;

    // Full microorder word driven by the decoder.
    typedef struct packed {
        logic       lec;
        logic       esc;
        logic       eri;
        logic       era;
        logic       eac;
        logic       incp;
        logic       ecp;
        logic       scp;
        logic       sri;
        logic       sac;
        logic       stop;
        logic [1:0] alu_op;
    } uorders_t;

endpackage

// File: rtl/simplez_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flag/memory-ready in, microorders and state out.
// Latency: wires only.
// Backpressure: mem_rdy stalls I0/O0 only in SIMPLEZ_MEMWAIT_EN builds.
interface simplez_ctrl_if;
    logic [2:0] co;
    logic       z;
    logic       mem_rdy;
    logic       lec;
    logic       esc;
    logic       eri;
    logic       era;
    logic       eac;
    logic       incp;
    logic       ecp;
    logic       scp;
    logic       sri;
    logic       sac;
    logic [1:0] alu_op;
    logic       stop;
    logic [2:0] state;

    // master: the controller; slave: the datapath / memory side.
    modport master (
        input  co, z, mem_rdy,
        output lec, esc, eri, era, eac, incp, ecp, scp, sri, sac, alu_op, stop, state
    );
    modport slave (
        output co, z, mem_rdy,
        input  lec, esc, eri, era, eac, incp, ecp, scp, sri, sac, alu_op, stop, state
    );
endinterface

// File: rtl/simplez_ctrl_dec.sv
// Microorder decoder: maps (state, co, z, mem_rdy) to the microorder word.
// Latency: purely combinational.
// Backpressure: with SIMPLEZ_MEMWAIT_EN, incp is held off until mem_rdy; otherwise mem_rdy is ignored.
module simplez_ctrl_dec
    import simplez_pkg::*;
(
    input  logic [2:0] state,
    input  logic [2:0] co,
    input  logic       z,
    input  logic       mem_rdy,
    output uorders_t   uo
);

    logic rdy;
`ifdef SIMPLEZ_MEMWAIT_EN
    assign rdy = mem_rdy;
`else
    logic unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;
    assign rdy = 1'b1;
`endif

    always_comb begin
        uo = '0;
        case (state)
            S_I0: begin
                uo.lec  = 1'b1;
                // CP advances only once the fetch has actually completed.
                uo.incp = rdy;
            end
            S_I1: uo.eri = 1'b1;
            S_D: begin
                case (opcode_e'(co))
                    OP_ST, OP_LD, OP_ADD: begin
                        uo.sri = 1'b1;
                        uo.era = 1'b1;
                    end
                    OP_BR: begin
                        uo.sri = 1'b1;
                        uo.era = 1'b1;
                        uo.ecp = 1'b1;
                    end
                    OP_BZ: begin
                        uo.era = 1'b1;
                        if (z) begin
                            uo.sri = 1'b1;
                            uo.ecp = 1'b1;
                        end else begin
                            uo.scp = 1'b1;
                        end
                    end
                    OP_CLR: begin
                        uo.eac    = 1'b1;
                        uo.alu_op = ALU_CLR;
                        uo.scp    = 1'b1;
                        uo.era    = 1'b1;
                    end
                    OP_DEC: begin
                        uo.eac    = 1'b1;
                        uo.alu_op = ALU_DEC;
                        uo.scp    = 1'b1;
                        uo.era    = 1'b1;
                    end
                    default: uo.stop = 1'b1;
                endcase
            end
            S_O0: begin
                if (opcode_e'(co) == OP_ST) begin
                    uo.sac = 1'b1;
                    uo.esc = 1'b1;
                end else if (opcode_e'(co) == OP_LD || opcode_e'(co) == OP_ADD) begin
                    uo.lec = 1'b1;
                end
            end
            S_O1: begin
                // Reload RA from CP so the next fetch addresses the next instruction.
                uo.scp = 1'b1;
                uo.era = 1'b1;
                if (opcode_e'(co) == OP_LD) begin
                    uo.eac    = 1'b1;
                    uo.alu_op = ALU_PASS;
                end else if (opcode_e'(co) == OP_ADD) begin
                    uo.eac    = 1'b1;
                    uo.alu_op = ALU_ADD;
                end
            end
            S_H:     uo.stop = 1'b1;
            default: uo = '0;
        endcase
    end

endmodule

// File: rtl/simplez_ctrl.sv
// Simplez control unit: state register (falling-edge) + next-state logic; outputs from simplez_ctrl_dec.
// Latency: microorders are combinational from state/co/z; state advances on each falling clk edge.
// Backpressure: SIMPLEZ_MEMWAIT_EN makes I0/O0 wait for mem_rdy; default build ignores mem_rdy.
// Ports: clk, rstn (async active-low), bus (simplez_ctrl_if.master).
module simplez_ctrl
    import simplez_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    simplez_ctrl_if.master bus
);

    state_e   state_q;
    state_e   state_d;
    uorders_t uo;
    uorders_t uo_g;
    logic     rdy;

`ifdef SIMPLEZ_MEMWAIT_EN
    assign rdy = bus.mem_rdy;
`else
    assign rdy = 1'b1;
`endif

    simplez_ctrl_dec u_dec (
        .state   (state_q),
        .co      (bus.co),
        .z       (bus.z),
        .mem_rdy (bus.mem_rdy),
        .uo      (uo)
    );

    always_comb begin
        state_d = S_I0;
        case (state_q)
            S_I0: state_d = rdy ? S_I1 : S_I0;
            S_I1: state_d = S_D;
            S_D: begin
                case (opcode_e'(bus.co))
                    OP_ST, OP_LD, OP_ADD: state_d = S_O0;
                    OP_HALT:              state_d = S_H;
                    default:              state_d = S_I0;
                endcase
            end
            S_O0:    state_d = rdy ? S_O1 : S_O0;
            S_O1:    state_d = S_I0;
            S_H:     state_d = S_H;
            default: state_d = S_I0;
        endcase
    end

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_I0;
        end else begin
            state_q <= state_d;
        end
    end

    // Gate with rstn so a mid-instruction reset kills esc (and everything else) at once.
    assign uo_g = rstn ? uo : '0;

    assign bus.lec    = uo_g.lec;
    assign bus.esc    = uo_g.esc;
    assign bus.eri    = uo_g.eri;
    assign bus.era    = uo_g.era;
    assign bus.eac    = uo_g.eac;
    assign bus.incp   = uo_g.incp;
    assign bus.ecp    = uo_g.ecp;
    assign bus.scp    = uo_g.scp;
    assign bus.sri    = uo_g.sri;
    assign bus.sac    = uo_g.sac;
    assign bus.alu_op = uo_g.alu_op;
    assign bus.stop   = uo_g.stop;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_simplez_ctrl.sv
// Bench for simplez_ctrl: table of per-instruction vectors, hand sequences, random instruction stream.
// Clock: state moves on negedge; inputs driven 1 after negedge, outputs sampled 2 after negedge.
module tb_simplez_ctrl;
    import simplez_pkg::*;

    logic clk  = 1'b1;
    logic rstn = 1'b0;

    simplez_ctrl_if bus ();

    simplez_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Standalone decoder copy to reach the unused state codes.
    logic [2:0] u_state = 3'd6;
    uorders_t   u_uo;
    simplez_ctrl_dec u_dec (
        .state   (u_state),
        .co      (bus.co),
        .z       (bus.z),
        .mem_rdy (bus.mem_rdy),
        .uo      (u_uo)
    );

    always #5 clk = ~clk;

`ifdef SIMPLEZ_MEMWAIT_EN
    localparam bit MEMWAIT = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif

    localparam logic [12:0] LEC  = 13'h1000;
    localparam logic [12:0] ESC  = 13'h0800;
    localparam logic [12:0] ERI  = 13'h0400;
    localparam logic [12:0] ERA  = 13'h0200;
    localparam logic [12:0] EAC  = 13'h0100;
    localparam logic [12:0] INCP = 13'h0080;
    localparam logic [12:0] ECP  = 13'h0040;
    localparam logic [12:0] SCP  = 13'h0020;
    localparam logic [12:0] SRI  = 13'h0010;
    localparam logic [12:0] SAC  = 13'h0008;
    localparam logic [12:0] STOP = 13'h0004;

    int total  = 0;
    int passed = 0;

    // alu_op only matters while eac is set.
    function automatic logic [12:0] norm(logic [12:0] v);
        return v[8] ? v : {v[12:2], 2'b00};
    endfunction

    function automatic logic [12:0] outs();
        return norm({bus.lec, bus.esc, bus.eri, bus.era, bus.eac, bus.incp, bus.ecp,
                     bus.scp, bus.sri, bus.sac, bus.stop, bus.alu_op});
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Check {state, outputs} in the current cycle, then move to the next cycle.
    task automatic cyc(string nm, logic [2:0] es, logic [12:0] eo);
        #1;
        chk(nm, {bus.state, outs()}, {es, norm(eo)});
        @(negedge clk);
        #1;
    endtask

    // Reference: what each instruction does in D, O0, O1.
    function automatic logic [12:0] exp_d(logic [2:0] c, logic zz);
        case (c)
            3'd0, 3'd1, 3'd2: return SRI | ERA;
            3'd3:             return SRI | ERA | ECP;
            3'd4:             return zz ? (SRI | ERA | ECP) : (SCP | ERA);
            3'd5:             return EAC | SCP | ERA | 13'd3;
            3'd6:             return EAC | SCP | ERA | 13'd2;
            default:          return STOP;
        endcase
    endfunction

    function automatic logic [12:0] exp_o0(logic [2:0] c);
        return (c == 3'd0) ? (SAC | ESC) : LEC;
    endfunction

    function automatic logic [12:0] exp_o1(logic [2:0] c);
        if (c == 3'd1) return SCP | ERA | EAC | 13'd0;
        if (c == 3'd2) return SCP | ERA | EAC | 13'd1;
        return SCP | ERA;
    endfunction

    // Runs one non-HALT instruction from I0 with random z / junk co / mem_rdy.
    task automatic run_instr(logic [2:0] c);
        bit rdy;
        int k;
        k = 0;
        do begin
            bus.co      = 3'($urandom_range(0, 7));
            bus.z       = 1'($urandom);
            bus.mem_rdy = (k >= 6) ? 1'b1 : 1'($urandom);
            rdy = MEMWAIT ? bus.mem_rdy : 1'b1;
            cyc("rnd_I0", 3'd0, LEC | (rdy ? INCP : 13'h0));
            k++;
        end while (!rdy);
        bus.co      = c;
        bus.z       = 1'($urandom);
        bus.mem_rdy = 1'($urandom);
        cyc("rnd_I1", 3'd1, ERI);
        bus.z       = 1'($urandom);
        bus.mem_rdy = 1'($urandom);
        cyc("rnd_D", 3'd2, exp_d(c, bus.z));
        if (c <= 3'd2) begin
            k = 0;
            do begin
                bus.z       = 1'($urandom);
                bus.mem_rdy = (k >= 6) ? 1'b1 : 1'($urandom);
                rdy = MEMWAIT ? bus.mem_rdy : 1'b1;
                cyc("rnd_O0", 3'd3, exp_o0(c));
                k++;
            end while (!rdy);
            bus.z       = 1'($urandom);
            bus.mem_rdy = 1'($urandom);
            cyc("rnd_O1", 3'd4, exp_o1(c));
        end
    endtask

    typedef struct {
        logic [2:0]  co;
        logic        z;
        logic [15:0] cycles;
        logic [12:0] d;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [15:0] n;
        logic [12:0] dseen;

        vt[0] = '{3'd0, 1'b0, 16'd5, SRI | ERA};
        vt[1] = '{3'd1, 1'b1, 16'd5, SRI | ERA};
        vt[2] = '{3'd2, 1'b0, 16'd5, SRI | ERA};
        vt[3] = '{3'd3, 1'b0, 16'd3, SRI | ERA | ECP};
        vt[4] = '{3'd4, 1'b0, 16'd3, SCP | ERA};
        vt[5] = '{3'd4, 1'b1, 16'd3, SRI | ERA | ECP};
        vt[6] = '{3'd5, 1'b1, 16'd3, EAC | SCP | ERA | 13'd3};
        vt[7] = '{3'd6, 1'b0, 16'd3, EAC | SCP | ERA | 13'd2};

        // Reset: everything low, state I0, even with inputs that would decode to something.
        bus.co = 3'd0; bus.z = 1'b1; bus.mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_state", {bus.state, outs()}, 16'h0000);
        @(negedge clk);
        #1;
        rstn = 1'b1;

        // Table: cycle count until back in I0, and D-state microorders.
        for (int i = 0; i < 8; i++) begin
            bus.co = vt[i].co; bus.z = vt[i].z; bus.mem_rdy = 1'b1;
            n = 16'd0;
            dseen = '0;
            do begin
                #1;
                if (bus.state == 3'd2) dseen = outs();
                n++;
                @(negedge clk);
                #1;
            end while (bus.state != 3'd0 && n < 16'd20);
            chk($sformatf("tbl%0d_cycles", i), n, vt[i].cycles);
            chk($sformatf("tbl%0d_D", i), {3'd0, dseen}, {3'd0, norm(vt[i].d)});
        end

        // Fetch with mem_rdy low.
        bus.co = 3'd3; bus.z = 1'b0; bus.mem_rdy = 1'b0;
`ifdef SIMPLEZ_MEMWAIT_EN
        for (int i = 0; i < 3; i++) cyc("mw_hold", 3'd0, LEC);
        bus.mem_rdy = 1'b1;
        cyc("mw_go", 3'd0, LEC | INCP);
`else
        cyc("nowait_I0", 3'd0, LEC | INCP);
`endif
        cyc("mr_I1", 3'd1, ERI);
        cyc("mr_D", 3'd2, SRI | ERA | ECP);

        // Random instruction stream against the reference.
        for (int i = 0; i < 60; i++) run_instr(3'($urandom_range(0, 6)));

        // ST aborted by reset in O0.
        bus.co = 3'd0; bus.mem_rdy = 1'b1;
        cyc("st_I0", 3'd0, LEC | INCP);
        cyc("st_I1", 3'd1, ERI);
        cyc("st_D", 3'd2, SRI | ERA);
        #1;
        chk("st_O0", {bus.state, outs()}, {3'd3, SAC | ESC});
        rstn = 1'b0;
        #1;
        chk("st_rst_esc", {bus.state, outs()}, 16'h0000);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        cyc("st_restart_I0", 3'd0, LEC | INCP);

        // HALT after reset release: I0, I1, D(stop), then H forever.
        rstn = 1'b0;
        bus.co = 3'd7;
        @(negedge clk);
        #1;
        rstn = 1'b1;
        cyc("halt_I0", 3'd0, LEC | INCP);
        cyc("halt_I1", 3'd1, ERI);
        cyc("halt_D", 3'd2, STOP);
        for (int i = 0; i < 11; i++) begin
            bus.co = 3'($urandom_range(0, 7));
            bus.z  = 1'($urandom);
            cyc($sformatf("halt_H%0d", i), 3'd5, STOP);
        end

        // Unused state codes decode to nothing.
        for (int i = 0; i < 8; i++) begin
            u_state     = (i % 2 == 0) ? 3'd6 : 3'd7;
            bus.co      = 3'(i);
            bus.z       = 1'($urandom);
            bus.mem_rdy = 1'($urandom);
            #1;
            chk($sformatf("unused_%0d", i), {3'd0, u_uo}, 16'h0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
